// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory refill arbiter.
// Holds the FSM state encoding, the burst owner encoding and default sizing.
// No ports; imported by mem_arb_sel and mem_refill_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  localparam int DEF_BURST_LEN    = 4;
  localparam int DEF_MAX_D_STREAK = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select for the refill arbiter plus the D-streak anti-starvation counter.
// Latency: winner is combinational from the requests; the streak updates at the clock edge.
// Ports: clk/rst, arb_en_i (arbiter idle), ic_req_i/dc_req_i in; win_vld_o, win_d_o (1 = D-cache wins) out.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,
  input  logic ic_req_i,
  input  logic dc_req_i,
  output logic win_vld_o,
  output logic win_d_o
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] d_streak_q;
  logic [SW-1:0] d_streak_d;
  logic          streak_full;

  assign streak_full = (d_streak_q == STREAK_MAX);

  always_comb begin
    win_vld_o  = arb_en_i & (ic_req_i | dc_req_i);
    // D takes precedence; I only wins a contended slot once D has used its streak.
    win_d_o    = dc_req_i & ~(ic_req_i & streak_full);
    d_streak_d = d_streak_q;
    if (win_vld_o) begin
      if (win_d_o && ic_req_i) begin
        if (!streak_full) d_streak_d = d_streak_q + SW'(1);
      end else begin
        // I grant, or an uncontended D grant, both restart the streak.
        d_streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_streak_q <= '0;
    else     d_streak_q <= d_streak_d;
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one external memory port between I-cache refills and D-cache refills/writebacks, one whole burst at a time.
// Ports: ic_* (refill only), dc_* (refill or writeback), mem_* (address phase, write beats, read beats), busy_o, err_o.
// Optional MEM_ARB_PERF_EN adds ic_wait_cnt_o, dc_wait_cnt_o and conflict_cnt_o saturating counters.
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic              ic_rlast_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_wready_o,
  output logic              dc_rvalid_o,
  output logic              dc_rlast_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wlast_o,
  input  logic              mem_wready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
`ifdef MEM_ARB_PERF_EN
 ,output logic [31:0]       ic_wait_cnt_o,
  output logic [31:0]       dc_wait_cnt_o,
  output logic [31:0]       conflict_cnt_o
`endif
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  arb_state_t        state_q;
  arb_owner_t        owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     beat_q;
  logic              err_q;

  logic win_vld, win_d;
  logic addr_ph, rd_ph, wr_ph, own_i, own_d, last_beat, stray;

  mem_arb_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_sel (
    .clk      (clk),
    .rst      (rst),
    .arb_en_i (state_q == IDLE),
    .ic_req_i (ic_req_i),
    .dc_req_i (dc_req_i),
    .win_vld_o(win_vld),
    .win_d_o  (win_d)
  );

  assign addr_ph   = (state_q == ADDR);
  assign rd_ph     = (state_q == RD);
  assign wr_ph     = (state_q == WR);
  assign own_i     = (owner_q == OWNER_I);
  assign own_d     = (owner_q == OWNER_D);
  assign last_beat = (beat_q == LAST_BEAT);
  // Beats arriving in a phase that cannot accept them are dropped and flagged.
  assign stray     = (mem_rvalid_i & ~rd_ph) | (mem_wready_i & ~wr_ph);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (stray) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            owner_q <= win_d ? OWNER_D : OWNER_I;
            we_q    <= win_d & dc_we_i;
            addr_q  <= win_d ? dc_addr_i : ic_addr_i;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (mem_ack_i) begin
            state_q <= we_q ? WR : RD;
            beat_q  <= '0;
          end
        end
        RD: begin
          if (mem_rvalid_i) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        WR: begin
          if (mem_wready_i) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address-phase signals are only driven while the address is being offered.
  assign mem_req_o   = addr_ph;
  assign mem_we_o    = addr_ph & we_q;
  assign mem_addr_o  = addr_ph ? addr_q : '0;

  assign ic_gnt_o    = addr_ph & mem_ack_i & own_i;
  assign dc_gnt_o    = addr_ph & mem_ack_i & own_d;

  // Read beats are steered only to the cache that owns the burst.
  assign ic_rvalid_o = rd_ph & own_i & mem_rvalid_i;
  assign ic_rlast_o  = ic_rvalid_o & last_beat;
  assign ic_rdata_o  = (rd_ph & own_i) ? mem_rdata_i : '0;
  assign dc_rvalid_o = rd_ph & own_d & mem_rvalid_i;
  assign dc_rlast_o  = dc_rvalid_o & last_beat;
  assign dc_rdata_o  = (rd_ph & own_d) ? mem_rdata_i : '0;

  assign mem_wdata_o = wr_ph ? dc_wdata_i : '0;
  assign mem_wlast_o = wr_ph & last_beat;
  assign dc_wready_o = wr_ph & mem_wready_i;

  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] ic_wait_q, dc_wait_q, conflict_q;
  logic        ic_done, dc_done;

  assign ic_done = ic_rlast_o;
  assign dc_done = dc_rlast_o | (mem_wlast_o & dc_wready_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_wait_q  <= '0;
      dc_wait_q  <= '0;
      conflict_q <= '0;
    end else begin
      if (ic_req_i && !ic_done && ic_wait_q != '1) ic_wait_q <= ic_wait_q + 32'd1;
      if (dc_req_i && !dc_done && dc_wait_q != '1) dc_wait_q <= dc_wait_q + 32'd1;
      if ((state_q == IDLE) && ic_req_i && dc_req_i && conflict_q != '1)
        conflict_q <= conflict_q + 32'd1;
    end
  end

  assign ic_wait_cnt_o  = ic_wait_q;
  assign dc_wait_cnt_o  = dc_wait_q;
  assign conflict_cnt_o = conflict_q;
`endif

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: a cycle table for a single refill and a single
// writeback, then hand-written sequences for arbitration order, back-to-back spacing,
// reset mid-burst and stray read beats.
module tb_mem_refill_arbiter;

  localparam int BURST = 4;

  logic        clk, rst;
  logic        ic_req, ic_gnt, ic_rvalid, ic_rlast;
  logic [31:0] ic_addr, ic_rdata;
  logic        dc_req, dc_we, dc_gnt, dc_wready, dc_rvalid, dc_rlast;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic        mem_req, mem_we, mem_ack, mem_wlast, mem_wready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] ic_wait_cnt, dc_wait_cnt, conflict_cnt;
`endif

  mem_refill_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_gnt_o(ic_gnt),
    .ic_rvalid_o(ic_rvalid), .ic_rlast_o(ic_rlast), .ic_rdata_o(ic_rdata),
    .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_gnt_o(dc_gnt), .dc_wready_o(dc_wready), .dc_rvalid_o(dc_rvalid),
    .dc_rlast_o(dc_rlast), .dc_rdata_o(dc_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .mem_wdata_o(mem_wdata), .mem_wlast_o(mem_wlast), .mem_wready_i(mem_wready),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .err_o(err)
`ifdef MEM_ARB_PERF_EN
   ,.ic_wait_cnt_o(ic_wait_cnt), .dc_wait_cnt_o(dc_wait_cnt), .conflict_cnt_o(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        ic_gnt, ic_rvalid, ic_rlast;
    logic [31:0] ic_rdata;
    logic        dc_gnt, dc_wready, dc_rvalid, dc_rlast;
    logic [31:0] dc_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wlast, busy, err;
  } obs_t;

  obs_t obs;
  assign obs = {ic_gnt, ic_rvalid, ic_rlast, ic_rdata, dc_gnt, dc_wready, dc_rvalid, dc_rlast,
                dc_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wlast, busy, err};

  typedef struct {
    logic        icr, dcr, we, ack, rv;
    logic [31:0] rdat;
    logic        wrdy;
    logic [31:0] wd;
    obs_t        exp;
  } vec_t;

  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for one table row; D-side read outputs and err are always 0 here.
  function automatic obs_t ex(input logic gi, rvi, rli, input logic [31:0] rdi,
                              input logic gd, wrd, mreq, mwe,
                              input logic [31:0] maddr, mwd, input logic wlast, bsy);
    obs_t o;
    o = '0;
    o.ic_gnt = gi;  o.ic_rvalid = rvi; o.ic_rlast = rli; o.ic_rdata = rdi;
    o.dc_gnt = gd;  o.dc_wready = wrd; o.mem_req = mreq; o.mem_we = mwe;
    o.mem_addr = maddr; o.mem_wdata = mwd; o.mem_wlast = wlast; o.busy = bsy;
    return o;
  endfunction

  function automatic vec_t v(input logic icr, dcr, we, ack, rv, input logic [31:0] rdat,
                             input logic wrdy, input logic [31:0] wd, input obs_t e);
    vec_t r;
    r.icr = icr; r.dcr = dcr; r.we = we; r.ack = ack; r.rv = rv;
    r.rdat = rdat; r.wrdy = wrdy; r.wd = wd; r.exp = e;
    return r;
  endfunction

  // Plays the memory side: acks immediately, returns BURST read beats 0xB0.. after each grant.
  task automatic serve(input int n_grants, input bit keep, input bit use_ic, input bit use_dc,
                       input int max_cyc, output string order, output int ic_gnt_cyc,
                       output int dc_last_cyc, output int ic_beats);
    int beats, idx, got;
    bit done;
    beats = 0; idx = 0; got = 0; done = 1'b0;
    order = ""; ic_gnt_cyc = -1; dc_last_cyc = -1; ic_beats = 0;
    ic_req = use_ic; dc_req = use_dc; dc_we = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (got >= n_grants && beats == 0 && !busy) done = 1'b1;
      else if (mem_req) mem_ack = 1'b1;
      else if (beats > 0) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hB0 + 32'(idx); idx++; beats--;
      end
      #1;
      if (ic_rvalid) begin
        ic_beats++;
        chk("ic_rdata", ic_rdata, 32'hB0 + 32'(idx - 1));
        chk("ic_rlast", 32'(ic_rlast), 32'(idx == BURST));
      end
      if (dc_rvalid) begin
        chk("dc_rdata", dc_rdata, 32'hB0 + 32'(idx - 1));
        chk("dc_rlast", 32'(dc_rlast), 32'(idx == BURST));
        if (dc_rlast) dc_last_cyc = cyc;
      end
      if (ic_gnt) begin
        order = {order, "I"}; got++; ic_gnt_cyc = cyc; beats = BURST; idx = 0;
        if (!keep) ic_req = 1'b0;
      end
      if (dc_gnt) begin
        order = {order, "D"}; got++; beats = BURST; idx = 0;
        if (!keep) dc_req = 1'b0;
      end
      if (got >= n_grants) begin ic_req = 1'b0; dc_req = 1'b0; end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL serve timeout: got %0d grants, expected %0d", got, n_grants);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string order, exp_order;
    int    gi_cyc, dl_cyc, ib;
    bit    g;
    obs_t  zero;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] conf0;
`endif
    zero = '0;
    rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0; mem_rvalid = 0;
    mem_wready = 0; mem_rdata = '0; dc_wdata = '0;
    ic_addr = 32'h100; dc_addr = 32'h200;

    // Refill of 0x100 with ack after two cycles, then writeback of 0x200 with a wready gap.
    vt.push_back(v(1,0,0,0,0,0,0,0, ex(0,0,0,0, 0,0,0,0, 0,0,0,0)));
    vt.push_back(v(1,0,0,0,0,0,0,0, ex(0,0,0,0, 0,0,1,0, 32'h100,0,0,1)));
    vt.push_back(v(1,0,0,0,0,0,0,0, ex(0,0,0,0, 0,0,1,0, 32'h100,0,0,1)));
    vt.push_back(v(1,0,0,1,0,0,0,0, ex(1,0,0,0, 0,0,1,0, 32'h100,0,0,1)));
    vt.push_back(v(0,0,0,0,1,32'hA0,0,0, ex(0,1,0,32'hA0, 0,0,0,0, 0,0,0,1)));
    vt.push_back(v(0,0,0,0,1,32'hA1,0,0, ex(0,1,0,32'hA1, 0,0,0,0, 0,0,0,1)));
    vt.push_back(v(0,0,0,0,1,32'hA2,0,0, ex(0,1,0,32'hA2, 0,0,0,0, 0,0,0,1)));
    vt.push_back(v(0,0,0,0,1,32'hA3,0,0, ex(0,1,1,32'hA3, 0,0,0,0, 0,0,0,1)));
    vt.push_back(v(0,0,0,0,0,0,0,0, ex(0,0,0,0, 0,0,0,0, 0,0,0,0)));
    vt.push_back(v(0,1,1,0,0,0,0,0, ex(0,0,0,0, 0,0,0,0, 0,0,0,0)));
    vt.push_back(v(0,1,1,1,0,0,0,0, ex(0,0,0,0, 1,0,1,1, 32'h200,0,0,1)));
    vt.push_back(v(0,0,0,0,0,0,1,32'hD0, ex(0,0,0,0, 0,1,0,0, 0,32'hD0,0,1)));
    vt.push_back(v(0,0,0,0,0,0,0,32'hD1, ex(0,0,0,0, 0,0,0,0, 0,32'hD1,0,1)));
    vt.push_back(v(0,0,0,0,0,0,1,32'hD1, ex(0,0,0,0, 0,1,0,0, 0,32'hD1,0,1)));
    vt.push_back(v(0,0,0,0,0,0,1,32'hD2, ex(0,0,0,0, 0,1,0,0, 0,32'hD2,0,1)));
    vt.push_back(v(0,0,0,0,0,0,1,32'hD3, ex(0,0,0,0, 0,1,0,0, 0,32'hD3,1,1)));
    vt.push_back(v(0,0,0,0,0,0,0,0, ex(0,0,0,0, 0,0,0,0, 0,0,0,0)));

    repeat (2) @(negedge clk);
    #1 chk_obs("reset outputs", obs, zero);
    @(negedge clk) rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      ic_req = vt[i].icr; dc_req = vt[i].dcr; dc_we = vt[i].we; mem_ack = vt[i].ack;
      mem_rvalid = vt[i].rv; mem_rdata = vt[i].rdat; mem_wready = vt[i].wrdy;
      dc_wdata = vt[i].wd;
      #1 chk_obs($sformatf("vec%0d", i), obs, vt[i].exp);
    end
    @(negedge clk);
    ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    mem_wready = 0; dc_wdata = '0;
`ifdef MEM_ARB_PERF_EN
    chk("ic_wait_cnt", ic_wait_cnt, 32'd4);
    chk("dc_wait_cnt", dc_wait_cnt, 32'd2);
    conf0 = conflict_cnt;
`endif

    // Both requesters saturate the port: D gets MAX_D_STREAK grants, then one I grant.
    serve(10, 1'b1, 1'b1, 1'b1, 600, order, gi_cyc, dl_cyc, ib);
    exp_order = "DDDDIDDDDI";
    chk("streak order len", 32'(order.len()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("streak grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
`ifdef MEM_ARB_PERF_EN
    chk("conflict_cnt delta", conflict_cnt - conf0, 32'd10);
`endif

    // Simultaneous arrival with streak cleared: D first, I granted two cycles after D's rlast.
    serve(2, 1'b0, 1'b1, 1'b1, 200, order, gi_cyc, dl_cyc, ib);
    exp_order = "DI";
    chk("same-cycle order len", 32'(order.len()), 32'd2);
    chk("same-cycle first", 32'(order[0]), 32'(exp_order[0]));
    chk("same-cycle second", 32'(order[1]), 32'(exp_order[1]));
    chk("rlast to I gnt gap", 32'(gi_cyc - dl_cyc), 32'd2);

    // Reset asserted during the third read beat of an I refill.
    ic_addr = 32'h300;
    @(negedge clk) ic_req = 1'b1;
    g = 1'b0;
    for (int c = 0; c < 10 && !g; c++) begin
      @(negedge clk) mem_ack = mem_req;
      #1;
      if (ic_gnt) begin g = 1'b1; chk("rst-test addr", mem_addr, 32'h300); end
    end
    chk("rst-test granted", 32'(g), 32'd1);
    ic_req = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk) mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hC0 + 32'(b);
    end
    @(negedge clk) mem_rvalid = 1'b1; mem_rdata = 32'hC2;
    #1 rst = 1'b1;
    #1 chk_obs("outputs in reset", obs, zero);
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk) rst = 1'b0; ic_req = 1'b1;
    #1 chk_obs("first cycle after release", obs, zero);
    serve(1, 1'b0, 1'b1, 1'b0, 50, order, gi_cyc, dl_cyc, ib);
    chk("reissue beats", 32'(ib), 32'd4);
    chk("reissue owner", 32'(order.len() > 0 ? order[0] : 8'h0), 32'("I"));
    chk("err clean before stray", 32'(err), 32'd0);

    // Stray read beat while idle: nothing forwarded, err set and sticky.
    @(negedge clk) mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    #1 chk("stray fwd", 32'({ic_rvalid, dc_rvalid}), 32'd0);
    @(negedge clk) mem_rvalid = 1'b0; mem_rdata = '0;
    #1 chk("err set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    #1 chk("err sticky", 32'(err), 32'd1);
    chk("idle after stray", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
